if_fetch_ctrl: RTL and testbench

Fetch-side request engine for the pipeline front end. It generates fetch PCs and drives the instruction SRAM-like interface with at most one outstanding request. It hands fetched instructions to decode and consumes the write-back flush/redirect (`ws_handle_ex`, `ex_pc`) and decode branch redirects. Flushes hitting an in-flight request are handled by cancelling that request's response.

---
 rtl/if_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch request engine: one outstanding SRAM-like request, flush cancellation, branch delay slot.
// Optional FETCH_ADEL_EN: misaligned fetch PCs raise ADEL instead of issuing a request.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_handle_ex,
  input  logic [31:0] ex_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_busy,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned BUS_W = 65;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [PC_W-1:0]   pc_q, pc_n;
  logic              cancel_q, cancel_n;
  logic              br_pend_q, br_pend_n;
  logic [PC_W-1:0]   br_tgt_q, br_tgt_n;
  logic [BUS_W-1:0]  bus_n;
  logic              accept;
  logic              adel_q, adel_n;
  logic              req_n, busy_n, valid_n;
  logic [PC_W-1:0]   addr_n;

`ifdef FETCH_ADEL_EN
  assign adel_q = |pc_q[1:0];
  assign adel_n = |pc_n[1:0];
  assign addr_n = pc_n;
`else
  assign adel_q = 1'b0;
  assign adel_n = 1'b0;
  assign addr_n = {pc_n[PC_W-1:2], 2'b00};
`endif

  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;

  // A request is only live once the registered req is up, so a post-reset REQ cycle cannot be accepted.
  assign accept = inst_sram_req & inst_sram_addr_ok;

  // Next-state: sequential/branch behaviour first, flush overrides last.
  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    cancel_n  = cancel_q;
    br_pend_n = br_pend_q;
    br_tgt_n  = br_tgt_q;
    bus_n     = fs_to_ds_bus;

    if (br_taken) begin
      br_pend_n = 1'b1;
      br_tgt_n  = br_target;
    end

    case (state_q)
      S_REQ: begin
        if (adel_q) begin
          state_n = S_HOLD;
          bus_n   = {1'b1, 32'h0, pc_q};
        end else if (accept) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (cancel_q) begin
            cancel_n = 1'b0;
            state_n  = S_REQ;
          end else begin
            state_n = S_HOLD;
            bus_n   = {1'b0, inst_sram_rdata, pc_q};
          end
        end
      end
      S_HOLD: begin
        if (ds_allowin) begin
          state_n   = S_REQ;
          pc_n      = br_pend_n ? br_tgt_n : PC_W'(pc_q + 32'd4);
          br_pend_n = 1'b0;
        end
      end
      default: state_n = S_REQ;
    endcase

    if (ws_handle_ex) begin
      pc_n      = ex_pc;
      br_pend_n = 1'b0;
      bus_n     = fs_to_ds_bus;
      case (state_q)
        S_REQ: begin
          state_n  = accept ? S_WAIT : S_REQ;
          cancel_n = accept;
        end
        S_WAIT: begin
          if (inst_sram_data_ok) begin
            state_n  = S_REQ;
            cancel_n = 1'b0;
          end else begin
            state_n  = S_WAIT;
            cancel_n = 1'b1;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    req_n   = (state_n == S_REQ) && !adel_n;
    valid_n = (state_n == S_HOLD);
    busy_n  = ((state_n == S_WAIT) && !cancel_n) || (state_n == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      cancel_q       <= 1'b0;
      br_pend_q      <= 1'b0;
      br_tgt_q       <= '0;
      inst_sram_req  <= 1'b0;
      inst_sram_addr <= '0;
      fs_to_ds_valid <= 1'b0;
      fs_to_ds_bus   <= '0;
      fs_busy        <= 1'b0;
    end else begin
      state_q        <= state_n;
      pc_q           <= pc_n;
      cancel_q       <= cancel_n;
      br_pend_q      <= br_pend_n;
      br_tgt_q       <= br_tgt_n;
      inst_sram_req  <= req_n;
      inst_sram_addr <= addr_n;
      fs_to_ds_valid <= valid_n;
      fs_to_ds_bus   <= bus_n;
      fs_busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: fetch, backpressure, branch delay slot, flush cancel, wrap, ADEL.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        ws_handle_ex;
  logic [31:0] ex_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_busy;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .ws_handle_ex      (ws_handle_ex),
    .ex_pc             (ex_pc),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .fs_busy           (fs_busy),
    .ds_allowin        (ds_allowin),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction at the current request: accept, return data next cycle.
  task automatic fetch(input logic [31:0] data);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = data;
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic flush(input logic [31:0] target);
    ws_handle_ex = 1'b1;
    ex_pc        = target;
    tick();
    ws_handle_ex = 1'b0;
  endtask

  task automatic consume();
    ds_allowin = 1'b1;
    tick();
    ds_allowin = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ws_handle_ex = 1'b0; ex_pc = '0;
    br_taken = 1'b0; br_target = '0;
    ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;

    tick(); tick();
    check("rst_req",   65'(inst_sram_req), 65'd0);
    check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    check("rst_bus",   fs_to_ds_bus, 65'd0);
    check("rst_busy",  65'(fs_busy), 65'd0);
    check("const_wr",  65'(inst_sram_wr), 65'd0);
    check("const_size", 65'(inst_sram_size), 65'd2);

    // Release reset and wait (bounded) for the first request.
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8 && !inst_sram_req; i++) tick();
    check("first_req",  65'(inst_sram_req), 65'd1);
    check("first_addr", 65'(inst_sram_addr), 65'(32'hbfc00000));

    // Basic fetch, data_ok two cycles after acceptance.
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    check("wait_req",  65'(inst_sram_req), 65'd0);
    check("wait_busy", 65'(fs_busy), 65'd1);
    tick();
    check("wait_valid", 65'(fs_to_ds_valid), 65'd0);
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11111111;
    tick();
    inst_sram_data_ok = 1'b0;
    check("f1_valid", 65'(fs_to_ds_valid), 65'd1);
    check("f1_bus",   fs_to_ds_bus, {1'b0, 32'h11111111, 32'hbfc00000});
    consume();
    check("f1_next_valid", 65'(fs_to_ds_valid), 65'd0);
    check("f1_next_req",   65'(inst_sram_req), 65'd1);
    check("f1_next_addr",  65'(inst_sram_addr), 65'(32'hbfc00004));

    // Backpressure: entry held for five cycles with no new request.
    fetch(32'h22222222);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 65'(fs_to_ds_valid), 65'd1);
      check("bp_bus",   fs_to_ds_bus, {1'b0, 32'h22222222, 32'hbfc00004});
      check("bp_req",   65'(inst_sram_req), 65'd0);
      tick();
    end
    consume();
    check("bp_next_addr", 65'(inst_sram_addr), 65'(32'hbfc00008));

    // Branch taken while the delay slot is held.
    fetch(32'h33333333);
    br_taken = 1'b1; br_target = 32'hbfc00100;
    tick();
    br_taken = 1'b0;
    check("br_ds_valid", 65'(fs_to_ds_valid), 65'd1);
    check("br_ds_bus",   fs_to_ds_bus, {1'b0, 32'h33333333, 32'hbfc00008});
    consume();
    check("br_req",  65'(inst_sram_req), 65'd1);
    check("br_addr", 65'(inst_sram_addr), 65'(32'hbfc00100));

    // Flush while waiting: response is discarded, refetch from ex_pc.
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    flush(32'hbfc00380);
    check("fw_busy",  65'(fs_busy), 65'd0);
    check("fw_req",   65'(inst_sram_req), 65'd0);
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef;
    tick();
    inst_sram_data_ok = 1'b0;
    check("fw_valid", 65'(fs_to_ds_valid), 65'd0);
    check("fw_req2",  65'(inst_sram_req), 65'd1);
    check("fw_addr",  65'(inst_sram_addr), 65'(32'hbfc00380));

    // Flush and branch together while holding: branch is dropped.
    fetch(32'h44444444);
    check("fb_hold_bus", fs_to_ds_bus, {1'b0, 32'h44444444, 32'hbfc00380});
    br_taken = 1'b1; br_target = 32'hbfc00100;
    flush(32'hbfc00200);
    br_taken = 1'b0;
    check("fb_valid", 65'(fs_to_ds_valid), 65'd0);
    check("fb_addr",  65'(inst_sram_addr), 65'(32'hbfc00200));
    fetch(32'h55555555);
    check("fb_bus", fs_to_ds_bus, {1'b0, 32'h55555555, 32'hbfc00200});
    consume();
    check("fb_next_addr", 65'(inst_sram_addr), 65'(32'hbfc00204));

    // Flush in REQ without and with acceptance.
    flush(32'hbfc00300);
    check("fr_req",  65'(inst_sram_req), 65'd1);
    check("fr_addr", 65'(inst_sram_addr), 65'(32'hbfc00300));
    inst_sram_addr_ok = 1'b1;
    flush(32'hbfc00400);
    inst_sram_addr_ok = 1'b0;
    check("fra_busy", 65'(fs_busy), 65'd0);
    inst_sram_data_ok = 1'b1;
    tick();
    inst_sram_data_ok = 1'b0;
    check("fra_valid", 65'(fs_to_ds_valid), 65'd0);
    check("fra_addr",  65'(inst_sram_addr), 65'(32'hbfc00400));

    // PC wraps at 2^32.
    flush(32'hfffffffc);
    fetch(32'h66666666);
    check("wrap_bus", fs_to_ds_bus, {1'b0, 32'h66666666, 32'hfffffffc});
    consume();
    check("wrap_addr", 65'(inst_sram_addr), 65'd0);

    // Misaligned fetch target.
    flush(32'hbfc00002);
`ifdef FETCH_ADEL_EN
    check("adel_req", 65'(inst_sram_req), 65'd0);
    tick();
    check("adel_valid", 65'(fs_to_ds_valid), 65'd1);
    check("adel_bus",   fs_to_ds_bus, {1'b1, 32'h0, 32'hbfc00002});
    check("adel_req2",  65'(inst_sram_req), 65'd0);
    flush(32'hbfc00000);
    check("adel_flush_valid", 65'(fs_to_ds_valid), 65'd0);
    check("adel_flush_req",   65'(inst_sram_req), 65'd1);
`else
    check("mis_req",  65'(inst_sram_req), 65'd1);
    check("mis_addr", 65'(inst_sram_addr), 65'(32'hbfc00000));
    fetch(32'h77777777);
    check("mis_bus", fs_to_ds_bus, {1'b0, 32'h77777777, 32'hbfc00002});
    consume();
`endif

    // Reset with a request outstanding: a late data_ok is ignored.
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h88888888;
    tick();
    inst_sram_data_ok = 1'b0;
    check("rmo_valid", 65'(fs_to_ds_valid), 65'd0);
    check("rmo_req",   65'(inst_sram_req), 65'd1);
    check("rmo_addr",  65'(inst_sram_addr), 65'(32'hbfc00000));
    tick();
    check("rmo_valid2", 65'(fs_to_ds_valid), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
